// File: rtl/core_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encoding, forward selects, register address width.
package core_ctrl_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // True when a writer address is a real register (not x0) and equals the reader address
  function automatic logic reg_match(input logic [REG_AW-1:0] wr, input logic [REG_AW-1:0] rd);
    return (wr != '0) && (wr == rd);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational operand forwarding selects; EX/MEM result wins over MEM/WB.
module forward_unit
  import core_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_reg_write,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_reg_write,
  output logic [1:0]        o_forward_a,
  output logic [1:0]        o_forward_b
);

  // Select source for each operand
  always_comb begin
    o_forward_a = FWD_RF;
    o_forward_b = FWD_RF;
    if (i_mem_reg_write && reg_match(i_mem_rd, i_rs1))     o_forward_a = FWD_MEM;
    else if (i_wb_reg_write && reg_match(i_wb_rd, i_rs1))  o_forward_a = FWD_WB;
    if (i_mem_reg_write && reg_match(i_mem_rd, i_rs2))     o_forward_b = FWD_MEM;
    else if (i_wb_reg_write && reg_match(i_wb_rd, i_rs2))  o_forward_b = FWD_WB;
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush sequencing, data-memory wait FSM with timeout, EX forwarding.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic              mem_mem_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              dmem_ack,
  output logic              dmem_req,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic              mem_wb_bubble,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              dmem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_mem_stall,
  output logic [31:0]       perf_lu_stall,
  output logic [31:0]       perf_flush
`endif
);

  ctrl_state_e      r_state;
  ctrl_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;
  logic             r_dmem_err;
  logic             w_dmem_err_nxt;
  logic             w_mem_acc;
  logic             w_mem_stall;
  logic             w_load_use;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  assign w_mem_acc  = mem_mem_read | mem_mem_write;
  assign w_load_use = ex_mem_read & (reg_match(ex_rd, id_rs1) | reg_match(ex_rd, id_rs2));

  forward_unit u_fwd (
    .i_rs1           (ex_rs1),
    .i_rs2           (ex_rs2),
    .i_mem_rd        (mem_rd),
    .i_mem_reg_write (mem_reg_write),
    .i_wb_rd         (wb_rd),
    .i_wb_reg_write  (wb_reg_write),
    .o_forward_a     (w_fwd_a),
    .o_forward_b     (w_fwd_b)
  );

  // FSM state, wait counter and sticky error register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_dmem_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_dmem_err <= w_dmem_err_nxt;
    end
  end

  // Next-state, wait counting and memory stall decode
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_dmem_err_nxt = r_dmem_err;
    w_mem_stall    = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_acc && !dmem_ack) begin
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = CNT_W'(1);
          w_mem_stall    = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end else begin
          w_mem_stall = 1'b1;
          if (r_wait_cnt == CNT_W'(MAX_WAIT)) begin
            w_state_nxt    = ERR;
            w_dmem_err_nxt = 1'b1;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
          end
        end
      end
      ERR: begin
        w_mem_stall = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // Prioritised stall/flush outputs; everything forced low while reset is asserted
  always_comb begin
    dmem_req      = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    forward_a     = FWD_RF;
    forward_b     = FWD_RF;
    dmem_err      = 1'b0;
    if (reset) begin
      dmem_req  = w_mem_acc && (r_state != ERR);
      forward_a = w_fwd_a;
      forward_b = w_fwd_b;
      dmem_err  = r_dmem_err;
      if (w_mem_stall) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_stall   = 1'b1;
        ex_mem_stall  = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_mem_stall;
  logic [31:0] r_perf_lu_stall;
  logic [31:0] r_perf_flush;
  logic        w_cnt_lu;
  logic        w_cnt_flush;

  assign w_cnt_lu    = w_load_use & ~w_mem_stall & ~ex_branch_taken;
  assign w_cnt_flush = ex_branch_taken & ~w_mem_stall;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perf_mem_stall <= '0;
      r_perf_lu_stall  <= '0;
      r_perf_flush     <= '0;
    end else begin
      if (w_mem_stall && (r_perf_mem_stall != '1)) r_perf_mem_stall <= r_perf_mem_stall + 32'(1);
      if (w_cnt_lu    && (r_perf_lu_stall  != '1)) r_perf_lu_stall  <= r_perf_lu_stall + 32'(1);
      if (w_cnt_flush && (r_perf_flush     != '1)) r_perf_flush     <= r_perf_flush + 32'(1);
    end
  end

  assign perf_mem_stall = reset ? r_perf_mem_stall : '0;
  assign perf_lu_stall  = reset ? r_perf_lu_stall  : '0;
  assign perf_flush     = reset ? r_perf_flush     : '0;
`endif

endmodule
